// File: rtl/fwd_hazard_unit_if.sv
// Signal bundle between ID decode, the forwarding/hazard controller and the EX operand muxes.
// The controller takes the slave modport; the decode/EX side takes master.
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;

  logic                  stall;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  ex_valid;
  logic [STAT_W-1:0]     stat_stalls;
  logic [STAT_W-1:0]     stat_fwds;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel, ex_valid, stat_stalls, stat_fwds
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel, ex_valid, stat_stalls, stat_fwds
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the RV64 pipeline.
// Optional feature macro: FWD_STATS_EN (stall / forwarded-operand statistics counters).
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 32
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.slave  pipe
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // WB producers are covered by the register file's write-then-read bypass,
  // so only the EX and MEM records take part in forwarding.
  logic                  ex_valid_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  ex_reg_write_q;
  logic                  ex_mem_read_q;
  logic                  mem_valid_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  mem_reg_write_q;

  logic [1:0] sel_a_q;
  logic [1:0] sel_b_q;
  logic [1:0] sel_a_d;
  logic [1:0] sel_b_d;
  logic       ex_hit_a;
  logic       ex_hit_b;
  logic       mem_hit_a;
  logic       mem_hit_b;
  logic       load_use;
  logic       bubble;

  function automatic logic hit(
    input logic                  valid,
    input logic                  reg_write,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  uses
  );
    return valid && reg_write && (rd != '0) && (rd == rs) && uses;
  endfunction

  always_comb begin
    ex_hit_a  = pipe.id_valid & hit(ex_valid_q, ex_reg_write_q, ex_rd_q, pipe.id_rs1, pipe.id_uses_rs1);
    ex_hit_b  = pipe.id_valid & hit(ex_valid_q, ex_reg_write_q, ex_rd_q, pipe.id_rs2, pipe.id_uses_rs2);
    mem_hit_a = pipe.id_valid & hit(mem_valid_q, mem_reg_write_q, mem_rd_q, pipe.id_rs1, pipe.id_uses_rs1);
    mem_hit_b = pipe.id_valid & hit(mem_valid_q, mem_reg_write_q, mem_rd_q, pipe.id_rs2, pipe.id_uses_rs2);

    // A flush kills the consumer, so it can never also need a stall.
    load_use = ex_mem_read_q & (ex_hit_a | ex_hit_b) & ~pipe.flush & ~rst;
    bubble   = pipe.flush | load_use;

    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!bubble) begin
      if (ex_hit_a)       sel_a_d = SEL_MEM;
      else if (mem_hit_a) sel_a_d = SEL_WB;
      if (ex_hit_b)       sel_b_d = SEL_MEM;
      else if (mem_hit_b) sel_b_d = SEL_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      sel_a_q         <= SEL_RF;
      sel_b_q         <= SEL_RF;
    end else begin
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
      if (bubble) begin
        ex_valid_q     <= 1'b0;
        ex_rd_q        <= '0;
        ex_reg_write_q <= 1'b0;
        ex_mem_read_q  <= 1'b0;
      end else begin
        ex_valid_q     <= pipe.id_valid;
        ex_rd_q        <= pipe.id_rd;
        ex_reg_write_q <= pipe.id_reg_write;
        ex_mem_read_q  <= pipe.id_mem_read;
      end
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign pipe.stall     = load_use;
  assign pipe.fwd_a_sel = sel_a_q;
  assign pipe.fwd_b_sel = sel_b_q;
  assign pipe.ex_valid  = ex_valid_q;

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] stalls_q;
  logic [STAT_W-1:0] fwds_q;
  logic [1:0]        fwd_inc;
  logic [STAT_W:0]   fwds_sum;

  always_comb begin
    fwd_inc  = {1'b0, |sel_a_d} + {1'b0, |sel_b_d};
    fwds_sum = {1'b0, fwds_q} + {{(STAT_W-1){1'b0}}, fwd_inc};
  end

  // Both counters saturate; the forward count can jump by two, hence the carry check.
  always_ff @(posedge clk) begin
    if (rst) begin
      stalls_q <= '0;
      fwds_q   <= '0;
    end else begin
      if (load_use && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
      fwds_q <= fwds_sum[STAT_W] ? '1 : fwds_sum[STAT_W-1:0];
    end
  end

  assign pipe.stat_stalls = stalls_q;
  assign pipe.stat_fwds   = fwds_q;
`else
  assign pipe.stat_stalls = {STAT_W{1'b0}};
  assign pipe.stat_fwds   = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a pipeline-history reference model.
module tb_fwd_hazard_unit;

  localparam int RW = 5;
  localparam int SW = 32;

`ifdef FWD_STATS_EN
  localparam logic [31:0] EXP_LU_STALLS = 32'd1;
  localparam logic [31:0] EXP_LU_FWDS   = 32'd2;
`else
  localparam logic [31:0] EXP_LU_STALLS = 32'd0;
  localparam logic [31:0] EXP_LU_FWDS   = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_ADDR_W(RW), .STAT_W(SW)) pipe ();

  fwd_hazard_unit #(.REG_ADDR_W(RW), .STAT_W(SW)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (pipe.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
    pipe.id_valid     = v;
    pipe.id_rs1       = rs1;
    pipe.id_rs2       = rs2;
    pipe.id_uses_rs1  = u1;
    pipe.id_uses_rs2  = u2;
    pipe.id_rd        = rd;
    pipe.id_reg_write = rw;
    pipe.id_mem_read  = mr;
    pipe.flush        = fl;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       r;
    logic       fl;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       e_st;
    logic [1:0] e_a;
    logic [1:0] e_b;
    logic       e_exv;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic fl, input logic v,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic mr,
                     input logic e_st, input logic [1:0] e_a, input logic [1:0] e_b,
                     input logic e_exv);
    vec_t t;
    t = '{r, fl, v, rs1, rs2, u1, u2, rd, rw, mr, e_st, e_a, e_b, e_exv};
    vq.push_back(t);
  endtask

  // ---------------- reference model: last two instructions that entered EX ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } rec_t;

  rec_t        m_ex, m_mem;
  logic [1:0]  m_a, m_b;
  logic        m_exv;
  logic [31:0] m_stalls, m_fwds;

  function automatic logic m_hit(input rec_t p, input logic [4:0] rs, input logic uses);
    return pipe.id_valid && uses && p.v && p.rw && (p.rd != 5'd0) && (p.rd == rs);
  endfunction

  function automatic logic m_stall();
    return !rst && !pipe.flush && m_ex.mr &&
           (m_hit(m_ex, pipe.id_rs1, pipe.id_uses_rs1) || m_hit(m_ex, pipe.id_rs2, pipe.id_uses_rs2));
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic uses);
    if (m_hit(m_ex, rs, uses))  return 2'd2;
    if (m_hit(m_mem, rs, uses)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_edge();
    logic       st;
    logic [1:0] na, nb;
    longint     sum;
    st = m_stall();
    if (rst) begin
      m_ex = '0; m_mem = '0; m_a = 2'd0; m_b = 2'd0; m_exv = 1'b0;
      m_stalls = 32'd0; m_fwds = 32'd0;
    end else begin
      na = (pipe.flush || st) ? 2'd0 : m_sel(pipe.id_rs1, pipe.id_uses_rs1);
      nb = (pipe.flush || st) ? 2'd0 : m_sel(pipe.id_rs2, pipe.id_uses_rs2);
`ifdef FWD_STATS_EN
      if (st && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
      sum = longint'(m_fwds) + longint'(na != 2'd0) + longint'(nb != 2'd0);
      m_fwds = (sum > 64'sd4294967295) ? 32'hFFFF_FFFF : sum[31:0];
`else
      sum = 0;
`endif
      m_mem = m_ex;
      if (pipe.flush || st) m_ex = '0;
      else m_ex = '{pipe.id_valid, pipe.id_rd, pipe.id_reg_write, pipe.id_mem_read};
      m_a = na; m_b = nb; m_exv = m_ex.v;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(pipe.stall), 32'd0);
    check("reset_sel_a", 32'(pipe.fwd_a_sel), 32'd0);
    check("reset_sel_b", 32'(pipe.fwd_b_sel), 32'd0);
    check("reset_ex_valid", 32'(pipe.ex_valid), 32'd0);
    check("reset_stat_stalls", pipe.stat_stalls, 32'd0);
    check("reset_stat_fwds", pipe.stat_fwds, 32'd0);
    rst = 1'b0;

    //   r     fl    v     rs1    rs2    u1    u2    rd     rw    mr    st    a     b     exv
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1); // add x5
    add(1'b0, 1'b0, 1'b1, 5'd5,  5'd7,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1); // add x6,x5,x7
    add(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // nop
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1); // add x5
    add(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // nop
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd5,  1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1); // sub x8,x1,x5
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1); // ld x5
    add(1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0); // add x6,x5,x5 stalls
    add(1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1); // reissued
    add(1'b0, 1'b0, 1'b1, 5'd6,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1); // addi x0,x6
    add(1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1); // add x9,x0,x0
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1); // add x9
    add(1'b0, 1'b0, 1'b1, 5'd9,  5'd9,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1); // EX beats MEM
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1); // ld x5
    add(1'b0, 1'b1, 1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // flush beats stall
    add(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // nop
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1); // ld x5
    add(1'b1, 1'b0, 1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // rst masks stall
    add(1'b0, 1'b0, 1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1); // records cleared
    add(1'b0, 1'b0, 1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1); // ld x5
    add(1'b0, 1'b0, 1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd6,  1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0); // ld x6,0(x5)
    add(1'b0, 1'b0, 1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd6,  1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 5'd6,  5'd0,  1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0); // ld x7,0(x6)
    add(1'b0, 1'b0, 1'b1, 5'd6,  5'd0,  1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // nop

    foreach (vq[i]) begin
      rst = vq[i].r;
      set_in(vq[i].v, vq[i].rs1, vq[i].rs2, vq[i].u1, vq[i].u2, vq[i].rd, vq[i].rw, vq[i].mr, vq[i].fl);
      #3;
      check($sformatf("vec%0d_stall", i), 32'(pipe.stall), 32'(vq[i].e_st));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sel_a", i), 32'(pipe.fwd_a_sel), 32'(vq[i].e_a));
      check($sformatf("vec%0d_sel_b", i), 32'(pipe.fwd_b_sel), 32'(vq[i].e_b));
      check($sformatf("vec%0d_ex_valid", i), 32'(pipe.ex_valid), 32'(vq[i].e_exv));
    end
    rst = 1'b0;

    // ---- load-use statistics ----
    rst = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_stat_stalls", pipe.stat_stalls, EXP_LU_STALLS);
    check("lu_stat_fwds", pipe.stat_fwds, EXP_LU_FWDS);

    // ---- reset while a stall is being raised ----
    set_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #2;
    check("midstall_stall_before_rst", 32'(pipe.stall), 32'd1);
    rst = 1'b1;
    #1;
    check("midstall_stall_in_rst", 32'(pipe.stall), 32'd0);
    @(posedge clk); #1;
    check("midstall_sel_a", 32'(pipe.fwd_a_sel), 32'd0);
    check("midstall_sel_b", 32'(pipe.fwd_b_sel), 32'd0);
    check("midstall_ex_valid", 32'(pipe.ex_valid), 32'd0);
    check("midstall_stat_stalls", pipe.stat_stalls, 32'd0);
    check("midstall_stat_fwds", pipe.stat_fwds, 32'd0);
    rst = 1'b0;
    #2;
    check("post_rst_stall", 32'(pipe.stall), 32'd0);
    @(posedge clk); #1;
    check("post_rst_ex_valid", 32'(pipe.ex_valid), 32'd1);
    check("post_rst_sel_a", 32'(pipe.fwd_a_sel), 32'd0);

    // ---- randomized traffic against the model ----
    rst = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_edge();
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 7) != 0,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
             5'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0);
      #3;
      check("rand_stall", 32'(pipe.stall), 32'(m_stall()));
      model_edge();
      @(posedge clk); #1;
      check("rand_sel_a", 32'(pipe.fwd_a_sel), 32'(m_a));
      check("rand_sel_b", 32'(pipe.fwd_b_sel), 32'(m_b));
      check("rand_ex_valid", 32'(pipe.ex_valid), 32'(m_exv));
      check("rand_stat_stalls", pipe.stat_stalls, m_stalls);
      check("rand_stat_fwds", pipe.stat_fwds, m_fwds);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Forwarding and load-use hazard controller for the RV64 pipeline.
- Tracks the destination register of the instructions in EX, MEM and WB.
- Produces the registered 2-bit operand-select codes consumed by the EX-stage 3:1 operand muxes (A and B).
- Raises the load-use stall that freezes PC/IF-ID and injects a bubble into EX.
- Sits between ID decode and the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register index width
STAT_W, 32, statistics counter width (only used under FWD_STATS_EN)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  source 1 index
id_rs2  in  REG_ADDR_W  source 2 index
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  REG_ADDR_W  destination index
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
flush  in  1  EX branch/jump redirect; kill ID instruction
stall  out  1  combinational; hold PC and IF/ID
fwd_a_sel  out  2  registered; EX operand A select
fwd_b_sel  out  2  registered; EX operand B select
ex_valid  out  1  EX slot holds a real instruction (0 = bubble)
stat_stalls  out  STAT_W  load-use stall cycles
stat_fwds  out  STAT_W  forwarded operands

Behaviour:
- Select encoding matches the EX muxes:
  - 00 = register-file operand
  - 01 = MEM/WB result
  - 10 = EX/MEM result
  - 11 is never driven.
- Internal tracking: three stage records (EX, MEM, WB), each holding {valid, rd, reg_write, mem_read}. They shift EX→MEM→WB every cycle; they never stall, because the back end does not stall.
- EX record load on each rising edge:
  - flush=1 → EX record loads a bubble (valid=0).
  - else stall=1 → EX record loads a bubble.
  - else → EX record loads {id_valid, id_rd, id_reg_write, id_mem_read}.
- Hazard source: a stage "hits" operand X iff all of the following hold:
  - stage valid and reg_write
  - stage rd != 0
  - stage rd == id_rsX
  - id_uses_rsX and id_valid
- Select computation, evaluated in ID and registered into fwd_*_sel on the edge the instruction enters EX:
  - EX record hits → 10 (the producer will be in MEM next cycle).
  - else MEM record hits → 01 (the producer will be in WB next cycle).
  - else → 00.
  - EX has priority over MEM (youngest producer wins).
  - Register x0 is never forwarded.
  - WB-stage producers are not forwarded; the register file writes in the first half and reads in the second, so ID already sees them.
- When a bubble is loaded into EX (flush or stall), fwd_a_sel and fwd_b_sel load 00.
- Load-use stall: stall=1 iff all of the following hold:
  - EX record hits for operand A or B
  - EX record mem_read=1
  - flush=0
- Stall lasts exactly 1 cycle. Next cycle the load is in MEM, so the held ID instruction is re-evaluated and gets 01.
- Flush beats stall: with flush=1, stall=0 and the ID instruction is discarded.
- Back-to-back loads feeding each other: each dependent load stalls once; no deadlock.
- Reset (any cycle, including mid-stall):
  - all stage records invalid
  - fwd_a_sel = fwd_b_sel = 00
  - ex_valid = 0
  - stall = 0 (inputs ignored while rst=1)
  - stat counters = 0
- Latency:
  - select codes: 1 cycle (ID→EX edge)
  - stall: 0 cycles (combinational from ID inputs and EX record)

Optional Feature:
FWD_STATS_EN:
- Defined:
  - stat_stalls increments on every cycle with stall=1.
  - stat_fwds increments by the number of non-00 select codes loaded (0, 1 or 2) on each edge.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- ADD x5 then ADD x6,x5,x7 back-to-back → second instr in EX with fwd_a_sel=10, fwd_b_sel=00, stall never asserted.
- ADD x5; NOP; SUB x8,x1,x5 → SUB in EX with fwd_b_sel=01.
- LD x5; ADD x6,x5,x5 → stall=1 for exactly 1 cycle, ex_valid=0 for one cycle, then ADD in EX with fwd_a_sel=fwd_b_sel=01.
- Write x0 then read x0, plus an EX and MEM producer both writing x9 followed by a read of x9 → x0 gives sel 00; x9 gives sel 10 (EX priority).
- LD x5 in EX, dependent in ID, flush=1 same cycle → stall=0, EX bubble, sel 00. Separately, rst asserted during a stall → all outputs 0 next cycle.
- With FWD_STATS_EN: the LD/ADD case → stat_stalls=1, stat_fwds=2. Without the macro → both 0.
